// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the processor data-memory port. Takes one read
//   or write at a time over a req/ack handshake, waits LATENCY cycles, then
//   commits the write or returns the read word. Used in place of a
//   zero-latency data memory so the datapath can be exercised against slow
//   memory.
//
// Ports
//   clk    in   1   clock, all state on posedge
//   rst_n  in   1   synchronous active-low reset
//   req    in   1   request valid, sampled only in IDLE
//   we     in   1   1 = write, 0 = read
//   addr   in   32  byte address
//   wdata  in   32  write data
//   be     in   4   write byte enables, be[i] -> wdata[8i+7:8i]
//   ack    out  1   one-cycle completion pulse
//   rdata  out  32  read data, valid with ack, held until the next ack
//   err    out  1   access fault, meaningful only while ack=1
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for req; request fields are latched on acceptance
// BUSY  | latency countdown, r_cnt counts down to 0
// RESP  | ack/err/rdata presented for exactly one cycle
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_in_idle;
  logic        w_enter_resp;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_be;
  logic [29:0] w_idx;
  logic [AW-1:0] w_widx;
  logic        w_fault;
  logic        w_commit_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_enter_resp = (w_state_nxt == ST_RESP);

  // With zero latency the commit happens on the accepting edge itself, so the
  // live inputs are decoded there; otherwise only the latched copy is used.
  assign w_sel_we    = w_in_idle ? we    : r_we;
  assign w_sel_addr  = w_in_idle ? addr  : r_addr;
  assign w_sel_wdata = w_in_idle ? wdata : r_wdata;
  assign w_sel_be    = w_in_idle ? be    : r_be;

  // Offset is modulo 2^32, so an address below BASE_ADDR wraps to a large
  // index and faults on the range check.
  assign w_idx       = 30'((w_sel_addr - BASE_ADDR) >> 2);
  assign w_widx      = w_idx[AW-1:0];
  assign w_fault     = (|w_sel_addr[1:0]) || ({2'b00, w_idx} >= 32'(DEPTH_WORDS));
  assign w_commit_wr = rst_n && w_enter_resp && w_sel_we && !w_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_in_idle && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= be;
      end
      if (w_enter_resp) begin
        r_ack <= 1'b1;
        r_err <= w_fault;
        if (w_fault) begin
          r_rdata <= 32'd0;
        end else if (!w_sel_we) begin
          r_rdata <= r_mem[w_widx];
        end
      end else begin
        r_ack <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  // Storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel_be[i]) begin
          r_mem[w_widx][8*i +: 8] <= w_sel_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req2, req0;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ack2, err2, ack0, err0;
  logic [31:0] rdata2, rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack2), .rdata(rdata2), .err(err2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge. Returns edges from acceptance to ack (20 = timeout).
  task automatic access(input bit sel0, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat);
    logic a_v;
    we = w; addr = a; wdata = d; be = b;
    if (sel0) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    lat = 0;
    a_v = sel0 ? ack0 : ack2;
    while (!a_v && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      a_v = sel0 ? ack0 : ack2;
    end
    rd = sel0 ? rdata0 : rdata2;
    er = sel0 ? err0 : err2;
    @(posedge clk); #1;
    chk("ack_drop", {31'd0, sel0 ? ack0 : ack2}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n_ack;
  logic [5:0]  pat;

  initial begin
    rst_n = 1'b0; req2 = 1'b0; req0 = 1'b0; we = 1'b0;
    addr = 32'd0; wdata = 32'd0; be = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack2}, 32'd0);
    chk("rst_err", {31'd0, err2}, 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    rst_n = 1'b1;

    // full write, first request right after reset
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_full_lat", lat, 32'd2);
    chk("wr_full_err", {31'd0, er}, 32'd0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_full_lat", lat, 32'd2);
    chk("rd_full", rd, 32'hDEADBEEF);
    chk("rd_full_err", {31'd0, er}, 32'd0);

    // partial write, lane 1 only
    access(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
    chk("wr_part_rdata_held", rd, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_part", rd, 32'hDEADAAEF);

    // misaligned write faults, clears rdata, no write
    access(1'b0, 1'b1, 32'h12, 32'h12345678, 4'hF, rd, er, lat);
    chk("wr_misal_err", {31'd0, er}, 32'd1);
    chk("wr_misal_rdata", rd, 32'd0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_after_misal", rd, 32'hDEADAAEF);

    // out of range read
    access(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    chk("rd_oor_err", {31'd0, er}, 32'd1);
    chk("rd_oor_rdata", rd, 32'd0);

    // last valid word
    access(1'b0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, rd, er, lat);
    chk("wr_top_err", {31'd0, er}, 32'd0);
    access(1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    chk("rd_top", rd, 32'h0BADF00D);
    chk("rd_top_err", {31'd0, er}, 32'd0);

    // be=0 write: acks, no change, rdata held
    access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("wr_be0_lat", lat, 32'd2);
    chk("wr_be0_err", {31'd0, er}, 32'd0);
    chk("wr_be0_rdata", rd, 32'h0BADF00D);
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_be0", rd, 32'hDEADAAEF);

    // prepare words for the busy test
    access(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);

    // read 0x20; inputs change and req pulses during BUSY
    we = 1'b0; addr = 32'h20; be = 4'h0; req2 = 1'b1;
    @(posedge clk); #1;              // E0
    req2 = 1'b0; we = 1'b1; addr = 32'h40; wdata = 32'h0; be = 4'hF;
    req2 = 1'b1;                     // seen at E1 while BUSY
    n_ack = 0; rd = 32'h0;
    @(posedge clk); #1;              // E1
    req2 = 1'b0;
    if (ack2) n_ack++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack2) begin n_ack++; rd = rdata2; end
    end
    chk("busy_ack_count", n_ack, 32'd1);
    chk("busy_rdata", rd, 32'h11111111);
    access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("busy_no_write", rd, 32'hCAFEF00D);

    // reset during BUSY aborts a write
    we = 1'b1; addr = 32'h20; wdata = 32'h22222222; be = 4'hF; req2 = 1'b1;
    @(posedge clk); #1;              // E0 accepted
    req2 = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack2) n_ack++;
    end
    chk("abort_ack_count", n_ack, 32'd0);
    access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("abort_rd", rd, 32'h11111111);

    // LATENCY=0 instance
    access(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    chk("l0_wr_lat", lat, 32'd0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("l0_rd_lat", lat, 32'd0);
    chk("l0_rd", rd, 32'hA5A5A5A5);
    we = 1'b0; addr = 32'h8; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = ack0;
    end
    req0 = 1'b0;
    chk("l0_b2b_pattern", {26'd0, pat}, 32'b010101);
    chk("l0_b2b_rdata", rdata0, 32'hA5A5A5A5);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
